alu_hilo: RTL and testbench

- HI/LO register unit that sits directly downstream of the combinational ALU in the execute stage.
- Commits the ALU's res_lo/res_hi for multiply, divide, mthi and mtlo into architectural HI/LO registers.
- Feeds reg_lo/reg_hi back to the ALU for mflo/mfhi.
- Models multi-cycle multiply/divide latency with a busy state machine and raises a stall to the pipeline on HI/LO hazards.

---
 rtl/alu_hilo_pkg.sv | 65 ++++++
 rtl/alu_hilo_ctr.sv | 31 +++
 rtl/alu_hilo.sv | 144 ++++++++++++++
 tb/tb_alu_hilo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_hilo_pkg.sv
// Shared ALU definitions for the HI/LO unit: function codes, op-class decode,
// HI/LO state encoding and default multiply/divide latencies.
package alu_hilo_pkg;

    localparam int FUNC_W      = 5;
    localparam int DEF_MUL_LAT = 3;
    localparam int DEF_DIV_LAT = 16;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD  = 5'd0,
        FN_SUB  = 5'd1,
        FN_AND  = 5'd2,
        FN_OR   = 5'd3,
        FN_XOR  = 5'd4,
        FN_NOR  = 5'd5,
        FN_SLT  = 5'd6,
        FN_SLTU = 5'd7,
        FN_SLL  = 5'd8,
        FN_SRL  = 5'd9,
        FN_SRA  = 5'd10,
        FN_LUI  = 5'd11,
        FN_MULS = 5'd12,
        FN_MULU = 5'd13,
        FN_DIVS = 5'd14,
        FN_DIVU = 5'd15,
        FN_MFHI = 5'd16,
        FN_MFLO = 5'd17,
        FN_MTHI = 5'd18,
        FN_MTLO = 5'd19
    } alu_func_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_e;

    function automatic logic is_md(input logic [FUNC_W-1:0] f);
        case (f)
            FN_MULS, FN_MULU, FN_DIVS, FN_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul(input logic [FUNC_W-1:0] f);
        case (f)
            FN_MULS, FN_MULU: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_mt(input logic [FUNC_W-1:0] f);
        case (f)
            FN_MTHI, FN_MTLO: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_mf(input logic [FUNC_W-1:0] f);
        case (f)
            FN_MFHI, FN_MFLO: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_hilo_ctr.sv
// Loadable down-counter used to time multiply/divide latency; done when at zero.
module alu_hilo_ctr #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    input  logic             clear,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear beats load, load beats decrement; holds at zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (enable && (count_r != '0)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/alu_hilo.sv
// HI/LO register unit behind the execute-stage ALU, with multi-cycle mul/div
// latency and hazard stall. ALU_HILO_FWD_EN forwards pending HI/LO in the commit cycle.
module alu_hilo
    import alu_hilo_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic              flush,
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] res_lo,
    input  logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] reg_lo,
    output logic [DATA_W-1:0] reg_hi,
    output logic              busy,
    output logic              stall
);

    hilo_state_e       state_r, state_s;
    logic [DATA_W-1:0] lo_r, hi_r, pend_lo_r, pend_hi_r;
    logic              md_s, mt_s, mf_s;
    logic              accept_s, issue_s, commit_s, fwd_s;
    logic              ctr_done_s, ctr_enable_s;
    logic [CNT_W-1:0]  load_val_s;

    assign md_s       = is_md(func);
    assign mt_s       = is_mt(func);
    assign mf_s       = is_mf(func);
    assign accept_s   = valid & ~stall & ~flush;
    assign issue_s    = accept_s & md_s & (state_r == ST_IDLE);
    assign commit_s   = (state_r == ST_BUSY) & ctr_done_s & ~flush;
    assign load_val_s = is_mul(func) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);

`ifdef ALU_HILO_FWD_EN
    assign fwd_s = (state_r == ST_BUSY) & ctr_done_s;
`else
    assign fwd_s = 1'b0;
`endif

    alu_hilo_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clock    (clock),
        .reset    (reset),
        .load     (issue_s),
        .load_val (load_val_s),
        .enable   (ctr_enable_s),
        .clear    (flush),
        .done     (ctr_done_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: flush or a finished count both return to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush || ctr_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: hazards only exist while a mul/div is outstanding.
    always_comb begin
        busy         = 1'b0;
        stall        = 1'b0;
        ctr_enable_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy         = 1'b0;
                stall        = 1'b0;
                ctr_enable_s = 1'b0;
            end
            ST_BUSY: begin
                busy         = 1'b1;
                stall        = valid & (md_s | mt_s | (mf_s & ~fwd_s));
                ctr_enable_s = 1'b1;
            end
            default: begin
                busy         = 1'b0;
                stall        = 1'b0;
                ctr_enable_s = 1'b0;
            end
        endcase
    end

    // Pending result captured at issue; discarded implicitly by flush/reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_lo_r <= '0;
            pend_hi_r <= '0;
        end else if (issue_s) begin
            pend_lo_r <= res_lo;
            pend_hi_r <= res_hi;
        end else begin
            pend_lo_r <= pend_lo_r;
            pend_hi_r <= pend_hi_r;
        end
    end

    // Architectural HI/LO: mul/div commit or mthi/mtlo writes (never both in one cycle).
    always_ff @(posedge clock) begin
        if (reset) begin
            lo_r <= '0;
            hi_r <= '0;
        end else if (commit_s) begin
            lo_r <= pend_lo_r;
            hi_r <= pend_hi_r;
        end else if (accept_s && (state_r == ST_IDLE)) begin
            lo_r <= (func == FN_MTLO) ? res_lo : lo_r;
            hi_r <= (func == FN_MTHI) ? res_hi : hi_r;
        end else begin
            lo_r <= lo_r;
            hi_r <= hi_r;
        end
    end

    assign reg_lo = fwd_s ? pend_lo_r : lo_r;
    assign reg_hi = fwd_s ? pend_hi_r : hi_r;

endmodule

// File: tb/tb_alu_hilo.sv
// Scoreboard bench for alu_hilo: a per-cycle reference model predicts stall/busy/HI/LO,
// a negedge monitor compares; directed scenarios plus randomized traffic.
module tb_alu_hilo;
    import alu_hilo_pkg::*;

    localparam int DW = 32;
    localparam int ML = 3;
    localparam int DL = 16;
`ifdef ALU_HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset, valid, flush;
    logic [FUNC_W-1:0] func;
    logic [DW-1:0]     res_lo, res_hi, reg_lo, reg_hi;
    logic              busy, stall;

    alu_hilo #(.DATA_W(DW), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clock(clock), .reset(reset), .valid(valid), .flush(flush), .func(func),
        .res_lo(res_lo), .res_hi(res_hi), .reg_lo(reg_lo), .reg_hi(reg_hi),
        .busy(busy), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          st;
        logic          bz;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural HI/LO plus one outstanding mul/div with busy cycles left.
    logic [DW-1:0] m_hi, m_lo, m_phi, m_plo;
    bit            m_inflight;
    int            m_rem;

    logic          last_stall, last_busy;
    logic [DW-1:0] last_lo;

    function automatic int op_class(input logic [FUNC_W-1:0] f);
        if (f == FN_MULS || f == FN_MULU || f == FN_DIVS || f == FN_DIVU) return 1;
        if (f == FN_MTHI || f == FN_MTLO) return 2;
        if (f == FN_MFHI || f == FN_MFLO) return 3;
        return 0;
    endfunction

    function automatic bit m_stall(input bit v, input logic [FUNC_W-1:0] f);
        int c;
        c = op_class(f);
        if (!v || !m_inflight) return 1'b0;
        if (c == 1 || c == 2) return 1'b1;
        if (c == 3) return !(FWD && m_rem == 1);
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the predicted outputs, advance the model.
    task automatic cycle(input bit r, input bit v, input bit fl, input logic [FUNC_W-1:0] f,
                         input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        exp_t e;
        bit   acc, fw;
        int   c;
        reset = r; valid = v; flush = fl; func = f; res_lo = lo; res_hi = hi;
        fw   = FWD && m_inflight && (m_rem == 1);
        e.st = m_stall(v, f);
        e.bz = m_inflight;
        e.lo = fw ? m_plo : m_lo;
        e.hi = fw ? m_phi : m_hi;
        sb_q.push_back(e);
        acc = v && !e.st && !fl;
        c   = op_class(f);
        @(negedge clock);
        last_stall = stall; last_busy = busy; last_lo = reg_lo;
        @(posedge clock);
        if (r) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_inflight = 0; m_rem = 0;
        end else if (m_inflight) begin
            if (fl) m_inflight = 0;
            else if (m_rem == 1) begin
                m_hi = m_phi; m_lo = m_plo; m_inflight = 0;
            end else m_rem = m_rem - 1;
        end else if (acc) begin
            if (c == 1) begin
                m_inflight = 1;
                m_rem = (f == FN_MULS || f == FN_MULU) ? ML : DL;
                m_plo = lo; m_phi = hi;
            end
            if (f == FN_MTLO) m_lo = lo;
            if (f == FN_MTHI) m_hi = hi;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, FN_ADD, $urandom, $urandom);
    endtask

    // Hold an instruction until the model says it is accepted.
    task automatic issue(input logic [FUNC_W-1:0] f, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        bit ok;
        for (int i = 0; i < 64; i++) begin
            ok = !m_stall(1'b1, f);
            cycle(1'b0, 1'b1, 1'b0, f, lo, hi);
            if (ok) return;
        end
        tests++; fails++;
        $display("FAIL issue_timeout: func %0d not accepted within 64 cycles", f);
    endtask

    // Monitor: every negedge the DUT presents one cycle's outputs.
    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            if (stall !== e.st || busy !== e.bz || reg_lo !== e.lo || reg_hi !== e.hi) begin
                fails++;
                $display("FAIL sb @%0t: got stall=%b busy=%b lo=%h hi=%h expected stall=%b busy=%b lo=%h hi=%h",
                         $time, stall, busy, reg_lo, reg_hi, e.st, e.bz, e.lo, e.hi);
            end
        end
    end

    initial begin
        logic [DW-1:0] q, ml;
        int n;
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_inflight = 0; m_rem = 0;
        reset = 1'b1; valid = 1'b0; flush = 1'b0; func = FN_ADD; res_lo = '0; res_hi = '0;
        @(posedge clock); #1;
        cycle(1'b1, 1'b0, 1'b0, FN_ADD, '0, '0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_lo", reg_lo, 32'd0);
        chk("reset_hi", reg_hi, 32'd0);

        issue(FN_MTLO, 32'h12345678, 32'h0BAD0BAD);
        chk("mtlo_lo", reg_lo, 32'h12345678);
        chk("mtlo_hi", reg_hi, 32'd0);
        chk("mtlo_stall", {31'd0, stall}, 32'd0);

        issue(FN_MULU, 32'hFFFFFFFE, 32'h00000001);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (last_busy) n++; else break;
        end
        chk("mul_busy_cycles", n, ML);
        chk("mul_hi", reg_hi, 32'h00000001);
        chk("mul_lo", reg_lo, 32'hFFFFFFFE);

        q = $urandom;
        issue(FN_DIVS, q, $urandom);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0, FN_MFLO, $urandom, $urandom);
            if (last_stall) n++; else break;
        end
        chk("div_mflo_stall_cycles", n, FWD ? DL - 1 : DL);
        chk("div_mflo_value", last_lo, q);

        issue(FN_MTHI, $urandom, 32'hAAAA5555);
        issue(FN_MTLO, 32'h5555AAAA, $urandom);
        issue(FN_DIVU, $urandom, $urandom);
        repeat (4) idle();
        cycle(1'b0, 1'b0, 1'b1, FN_ADD, '0, '0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", reg_hi, 32'hAAAA5555);
        chk("flush_lo", reg_lo, 32'h5555AAAA);

        ml = $urandom;
        issue(FN_MULS, ml, $urandom);
        issue(FN_MTHI, $urandom, 32'hDEADBEEF);
        chk("mthi_after_mul_hi", reg_hi, 32'hDEADBEEF);
        chk("mthi_after_mul_lo", reg_lo, ml);

        issue(FN_MULU, $urandom, $urandom);
        idle();
        cycle(1'b1, 1'b0, 1'b0, FN_ADD, '0, '0);
        chk("rst_busy_busy", {31'd0, busy}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy_lo", reg_lo, 32'd0);
        chk("rst_busy_hi", reg_hi, 32'd0);
        issue(FN_MULU, 32'h01020304, 32'h0A0B0C0D);
        repeat (ML) idle();
        chk("post_rst_mul_lo", reg_lo, 32'h01020304);
        chk("post_rst_mul_hi", reg_hi, 32'h0A0B0C0D);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  FUNC_W'($urandom_range(0, 23)), $urandom, $urandom);
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clock);
        if (sb_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
